// File: rtl/picorv32_mem_responder_pkg.sv
// Shared types and helpers for the picorv32 native-bus memory responder.
//
// Contents:
//   mem_state_e        responder FSM states (IDLE -> WAIT -> RESP)
//   LFSR_SEED/TAPS     reset seed and feedback taps of the optional stall LFSR
//   mem_req_t          request fields captured when a bus request is accepted
//   merge_bytes()      byte-strobed merge of write data into a stored word
//   addr_out_of_range  window check for a byte address against base/depth
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } mem_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } mem_req_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic addr_out_of_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [31:0] word_off;
        word_off = (addr - base) >> 2;
        return (addr < base) || (word_off >= depth);
    endfunction

endpackage

// File: rtl/picorv32_mem_responder_lfsr.sv
// Random stall source for the memory responder.
// Only built when MEM_STALL_LFSR_EN is defined.
//
// 16-bit Fibonacci LFSR, taps 16,14,13,11. It is seeded on reset and
// advances every cycle. The two low bits supply 0..3 extra wait states.
//
// Ports:
//   clk    in   1  clock, posedge
//   reset  in   1  synchronous active-high reset (reloads the seed)
//   stall  out  2  current lfsr[1:0]
`ifdef MEM_STALL_LFSR_EN
module mem_stall_lfsr
    import picorv32_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] stall
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign stall = lfsr[1:0];

endmodule
`endif

// File: rtl/picorv32_mem_responder.sv
// Registered single-port memory responder for the picorv32 native valid/ready bus.
// Provides separate fetch/data wait states, a base-address window with
// out-of-range reporting, a backdoor word-write port and saturating
// read/write transaction counters.
//
// Optional feature: define MEM_STALL_LFSR_EN to add 0..3 pseudo-random
// stall cycles per access, from mem_stall_lfsr.
//
// Ports:
//   clk        in   1      clock, posedge
//   reset      in   1      synchronous active-high reset
//   mem_valid  in   1      CPU request valid
//   mem_instr  in   1      request is an instruction fetch
//   mem_addr   in   32     byte address, bits [1:0] ignored
//   mem_wdata  in   32     write data
//   mem_wstrb  in   4      byte write strobes, 0 = read
//   mem_ready  out  1      one-cycle completion pulse
//   mem_rdata  out  32     read data, valid while mem_ready
//   bd_we      in   1      backdoor word write enable
//   bd_addr    in   AW     backdoor word index
//   bd_wdata   in   32     backdoor write data
//   err_oor    out  1      pulse with mem_ready when the access was out of range
//   err_proto  out  1      pulse after mem_valid dropped during a wait
//   rd_count   out  CNT_W  completed reads, saturating
//   wr_count   out  CNT_W  completed writes, saturating
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS       = 4096,
    parameter  logic [31:0] BASE_ADDR         = 32'h0000_0000,
    parameter  int unsigned DATA_WAIT_CYCLES  = 0,
    parameter  int unsigned INSTR_WAIT_CYCLES = 0,
    parameter  logic [31:0] ERR_RDATA         = 32'hDEAD_BEEF,
    parameter  int unsigned CNT_W             = 16,
    localparam int unsigned AW                = $clog2(DEPTH_WORDS)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    input  logic             bd_we,
    input  logic [AW-1:0]    bd_addr,
    input  logic [31:0]      bd_wdata,
    output logic             err_oor,
    output logic             err_proto,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    mem_state_e  state, state_next;
    logic [31:0] wait_cnt, wait_next;
    logic [31:0] wait_base, wait_load;
    mem_req_t    req, req_next;

    logic          enter_resp;
    logic          abort;
    logic          complete;
    logic          oor_next;
    logic          oor_cur;
    logic [AW-1:0] idx_next;
    logic [AW-1:0] idx_cur;

    logic [31:0] mem [DEPTH_WORDS];

    // Fetch flag is captured with the request for observability only; the
    // wait count is already chosen at accept time.
    logic req_instr_unused;
    assign req_instr_unused = req.instr;

    function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

    assign wait_base = mem_instr ? 32'(INSTR_WAIT_CYCLES) : 32'(DATA_WAIT_CYCLES);

`ifdef MEM_STALL_LFSR_EN
    logic [1:0] stall;

    mem_stall_lfsr u_stall_lfsr (
        .clk   (clk),
        .reset (reset),
        .stall (stall)
    );

    assign wait_load = wait_base + {30'd0, stall};
`else
    assign wait_load = wait_base;
`endif

    // Next state, wait counter and request capture.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        req_next   = req;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    req_next.addr  = mem_addr;
                    req_next.wdata = mem_wdata;
                    req_next.wstrb = mem_wstrb;
                    req_next.instr = mem_instr;
                    wait_next      = wait_load;
                    state_next     = (wait_load == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mem_valid) begin
                    state_next = ST_IDLE;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt - 32'd1;
                    if (wait_cnt == 32'd1) begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                wait_next  = '0;
            end
        endcase
    end

    assign enter_resp = (state_next == ST_RESP);
    assign abort      = (state == ST_WAIT) && !mem_valid;
    assign complete   = (state == ST_RESP);

    // Read side looks at the request as it will be latched on this edge,
    // so an IDLE->RESP zero-wait access samples the array immediately.
    assign oor_next = addr_out_of_range(req_next.addr, BASE_ADDR, DEPTH_WORDS);
    assign idx_next = word_index(req_next.addr);
    assign oor_cur  = addr_out_of_range(req.addr, BASE_ADDR, DEPTH_WORDS);
    assign idx_cur  = word_index(req.addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            err_oor   <= 1'b0;
            err_proto <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            req       <= req_next;
            mem_ready <= enter_resp;
            err_oor   <= enter_resp && oor_next;
            err_proto <= abort;
            if (enter_resp) begin
                mem_rdata <= oor_next ? ERR_RDATA : mem[idx_next];
            end
            if (complete) begin
                if (req.wstrb == '0) begin
                    if (rd_count != '1) begin
                        rd_count <= rd_count + 1'b1;
                    end
                end else begin
                    if (wr_count != '1) begin
                        wr_count <= wr_count + 1'b1;
                    end
                end
            end
        end
    end

    // Storage: CPU write commits on the edge leaving RESP; a backdoor write
    // to the same word on the same edge is issued later and therefore wins.
    always_ff @(posedge clk) begin
        if (!reset && complete && (req.wstrb != '0) && !oor_cur) begin
            mem[idx_cur] <= merge_bytes(mem[idx_cur], req.wdata, req.wstrb);
        end
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Scoreboard bench for picorv32_mem_responder.
// The driver pushes the expected response of each accepted request; the
// monitor pops and compares whenever mem_ready is seen. Expected read data
// comes from a word-array model updated with byte-level writes.
// Build with or without MEM_STALL_LFSR_EN; the latency window widens by 3.
module tb_picorv32_mem_responder;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned AW     = 12;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int unsigned DW     = 1;
    localparam int unsigned IW     = 3;
    localparam logic [31:0] ERR    = 32'hDEAD_BEEF;
    localparam int unsigned CNT_W  = 8;
    localparam int          SAT    = 255;
    localparam int unsigned REGION = 64;
`ifdef MEM_STALL_LFSR_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk;
    logic             reset;
    logic             mem_valid;
    logic             mem_instr;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic             bd_we;
    logic [AW-1:0]    bd_addr;
    logic [31:0]      bd_wdata;
    logic             err_oor;
    logic             err_proto;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;

    picorv32_mem_responder #(
        .DEPTH_WORDS       (DEPTH),
        .BASE_ADDR         (BASE),
        .DATA_WAIT_CYCLES  (DW),
        .INSTR_WAIT_CYCLES (IW),
        .ERR_RDATA         (ERR),
        .CNT_W             (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .err_oor   (err_oor),
        .err_proto (err_proto),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        bit          oor;
        int          issue;
        int          lat_min;
        int          lat_max;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          exp_rd = 0;
    int          exp_wr = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          proto_expected = 1'b0;
    bit          prev_ready = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_event(input string name, input string detail);
        n_checks++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic finish_sim();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Monitor: every completion is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (mem_ready) begin
            if (prev_ready) fail_event("ready_pulse", "mem_ready high on consecutive cycles");
            if (sb.size() == 0) begin
                fail_event("unexpected_ready", "mem_ready with no outstanding request");
            end else begin
                e   = sb.pop_front();
                lat = cyc - e.issue;
                n_checks++;
                if (lat >= e.lat_min && lat <= e.lat_max) n_pass++;
                else $display("FAIL latency: got %0d expected %0d..%0d", lat, e.lat_min, e.lat_max);
                if (e.is_read) check32("rdata", mem_rdata, e.rdata);
                check32("err_oor", 32'(err_oor), 32'(e.oor));
            end
        end else if (err_oor) begin
            fail_event("err_oor_stray", "err_oor high without mem_ready");
        end
        if (err_proto && !proto_expected) fail_event("err_proto_stray", "err_proto high unexpectedly");
        prev_ready = mem_ready;
    end

    task automatic check_counters(input string tag);
        check32({tag, "_rd_count"}, 32'(rd_count), 32'((exp_rd > SAT) ? SAT : exp_rd));
        check32({tag, "_wr_count"}, 32'(wr_count), 32'((exp_wr > SAT) ? SAT : exp_wr));
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_ready"}, 32'(mem_ready), 32'd0);
        check32({tag, "_rdata"}, mem_rdata, 32'd0);
        check32({tag, "_err_oor"}, 32'(err_oor), 32'd0);
        check32({tag, "_err_proto"}, 32'(err_proto), 32'd0);
        check32({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        check32({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    task automatic bd_write(input int unsigned idx, input logic [31:0] val);
        bd_we    = 1'b1;
        bd_addr  = AW'(idx);
        bd_wdata = val;
        model[idx] = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // One complete bus access. Called at a negedge; returns at a negedge
    // at least one cycle after the completion.
    task automatic access(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit collide, input logic [31:0] bd_val);
        exp_t        e;
        bit          oor;
        int unsigned idx;
        int          w;
        bit          got;
        oor = (addr < BASE) || (((addr - BASE) / 4) >= DEPTH);
        idx = oor ? 0 : (addr - BASE) / 4;
        w   = instr ? int'(IW) : int'(DW);
        e.is_read = (wstrb == 4'b0000);
        e.oor     = oor;
        e.rdata   = oor ? ERR : model[idx];
        e.lat_min = 1 + w;
        e.lat_max = 1 + w + EXTRA;
        if (!e.is_read && !oor) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        if (collide && !oor) model[idx] = bd_val;
        if (e.is_read) exp_rd++;
        else exp_wr++;

        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        e.issue   = cyc;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
        if (!got) begin
            fail_event("ready_timeout", "no mem_ready within 40 cycles");
            finish_sim();
        end
        if (collide && !oor) begin
            bd_we    = 1'b1;
            bd_addr  = AW'(idx);
            bd_wdata = bd_val;
            @(negedge clk);
            bd_we = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 99);
        if (sel < 88) return BASE + 32'($urandom_range(0, REGION - 1) * 4) + 32'($urandom_range(0, 3));
        else if (sel < 93) return BASE - 32'($urandom_range(1, 1000) * 4);
        else if (sel < 98) return BASE + DEPTH * 4 + 32'($urandom_range(0, 32'hFFFF));
        else return 32'hFFFF_FFFC;
    endfunction

    initial begin
        #1_000_000;
        fail_event("global_timeout", "simulation time limit reached");
        finish_sim();
    end

    initial begin
        logic [31:0] wd;
        bit          ins;
        logic [3:0]  st;
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_wdata  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int unsigned i = 0; i < REGION; i++) bd_write(i, $urandom);
        bd_write(0, 32'h0000_0013);
        bd_write(5, 32'h1122_3344);
        bd_write(DEPTH - 1, 32'hCAFE_F00D);

        // Basic read of word 0, then fetch vs data latency.
        access(0, BASE, 32'h0, 4'b0000, 0, 32'h0);
        check_counters("first_read");
        access(1, BASE + 4, 32'h0, 4'b0000, 0, 32'h0);
        access(0, BASE + 8, 32'h0, 4'b0000, 0, 32'h0);

        // Single byte lane write and readback, low address bits ignored.
        access(0, BASE + 20, 32'h00AB_0000, 4'b0100, 0, 32'h0);
        access(0, BASE + 22, 32'h0, 4'b0000, 0, 32'h0);
        check32("byte_merge_model", model[5], 32'h11AB_3344);
        check_counters("byte_write");

        // Window edges: beyond the top, below the base, last valid word.
        access(0, BASE + 32'h4000, 32'h0, 4'b0000, 0, 32'h0);
        access(0, BASE + 32'h4000, 32'h5555_AAAA, 4'b1111, 0, 32'h0);
        access(0, BASE, 32'h0, 4'b0000, 0, 32'h0);
        access(1, BASE - 4, 32'h0, 4'b0000, 0, 32'h0);
        access(0, BASE + 32'h3FFC, 32'h0, 4'b0000, 0, 32'h0);

        // Backdoor and CPU write hit the same word on the same edge.
        access(0, BASE + 12, 32'h1234_5678, 4'b1111, 1, 32'hB00C_D00D);
        access(0, BASE + 12, 32'h0, 4'b0000, 0, 32'h0);
        check_counters("directed");

        // Fetch abandoned after two cycles of waiting.
        mem_valid = 1'b1;
        mem_instr = 1'b1;
        mem_addr  = BASE + 16;
        mem_wstrb = 4'b0000;
        repeat (2) @(negedge clk);
        mem_valid      = 1'b0;
        proto_expected = 1'b1;
        @(negedge clk);
        check32("err_proto_pulse", 32'(err_proto), 32'd1);
        @(negedge clk);
        check32("err_proto_clear", 32'(err_proto), 32'd0);
        proto_expected = 1'b0;
        check_counters("abort");

        // Reset while a data write is waiting: write discarded.
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = BASE + 28;
        mem_wdata = ~model[7];
        mem_wstrb = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset     = 1'b0;
        mem_valid = 1'b0;
        exp_rd    = 0;
        exp_wr    = 0;
        repeat (2) @(negedge clk);
        access(0, BASE + 28, 32'h0, 4'b0000, 0, 32'h0);
        check_counters("after_reset");

        // Random traffic; enough reads to saturate the 8-bit read counter.
        for (int t = 0; t < 500; t++) begin
            ins = ($urandom_range(0, 3) == 0);
            st  = (ins || $urandom_range(0, 99) < 55) ? 4'b0000 : 4'($urandom_range(1, 15));
            wd  = $urandom;
            access(ins, rand_addr(), wd, st, ($urandom_range(0, 19) == 0), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (t % 100 == 99) check_counters("random");
        end

        repeat (5) @(negedge clk);
        check32("scoreboard_empty", 32'(sb.size()), 32'd0);
        finish_sim();
    end

endmodule
